// File: rtl/pol2rec23.sv
// Iterative CORDIC polar-to-rectangular converter (rotation mode), one micro-rotation per clock.
// Modulus and X/Y are Q16.16, angle is degrees in Q8.24.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | waiting for start; results hold
//  S_ROT   | one CORDIC micro-rotation per enabled clock
//  S_SCALE | apply 1/K gain correction, latch x_res/y_res
//  S_DONE  | results valid, done high; start here chains a new conversion
module pol2rec23 #(
    parameter int NITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        start,
    input  logic [31:0] mod_in,
    input  logic [31:0] angle_in,
    output logic [31:0] x_res,
    output logic [31:0] y_res,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(NITER);
    localparam logic signed [31:0] ANG_P90 = 32'sh5A000000;
    localparam logic signed [31:0] ANG_M90 = -32'sh5A000000;
    localparam logic signed [32:0] ANG_90_Z = 33'sh05A000000;
    localparam logic [31:0] KINV = 32'h4DBA76D4;

    typedef enum logic [1:0] {S_IDLE, S_ROT, S_SCALE, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic signed [33:0] x_q, x_d, y_q, y_d;
    logic signed [32:0] z_q, z_d;
    logic [31:0]        xr_q, xr_d, yr_q, yr_d;

    logic signed [33:0] mod_ext, x_sh, y_sh;
    logic signed [32:0] ang_ext, atan_z;
    logic signed [31:0] angle_s;
    logic signed [65:0] prod_x, prod_y;
    logic [4:0]         idx;
    logic               unused_prod_bits;

    // atan(2^-i) in degrees, Q8.24
    function automatic logic [31:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:  atan_lut = 32'h2D000000;
            5'd1:  atan_lut = 32'h1A90A731;
            5'd2:  atan_lut = 32'h0E094740;
            5'd3:  atan_lut = 32'h07200112;
            5'd4:  atan_lut = 32'h03938AA6;
            5'd5:  atan_lut = 32'h01CA3795;
            5'd6:  atan_lut = 32'h00E52A1B;
            5'd7:  atan_lut = 32'h007296D8;
            5'd8:  atan_lut = 32'h00394BA5;
            5'd9:  atan_lut = 32'h001CA5DA;
            5'd10: atan_lut = 32'h000E52EE;
            5'd11: atan_lut = 32'h00072977;
            5'd12: atan_lut = 32'h000394BC;
            5'd13: atan_lut = 32'h0001CA5E;
            5'd14: atan_lut = 32'h0000E52F;
            5'd15: atan_lut = 32'h00007297;
            5'd16: atan_lut = 32'h0000394C;
            5'd17: atan_lut = 32'h00001CA6;
            5'd18: atan_lut = 32'h00000E53;
            5'd19: atan_lut = 32'h00000729;
            5'd20: atan_lut = 32'h00000395;
            5'd21: atan_lut = 32'h000001CA;
            5'd22: atan_lut = 32'h000000E5;
            5'd23: atan_lut = 32'h00000073;
            5'd24: atan_lut = 32'h00000039;
            5'd25: atan_lut = 32'h0000001D;
            5'd26: atan_lut = 32'h0000000E;
            5'd27: atan_lut = 32'h00000007;
            5'd28: atan_lut = 32'h00000004;
            5'd29: atan_lut = 32'h00000002;
            5'd30: atan_lut = 32'h00000001;
            default: atan_lut = 32'h00000000;
        endcase
    endfunction

    assign mod_ext = {{2{mod_in[31]}}, mod_in};
    assign ang_ext = {angle_in[31], angle_in};
    assign angle_s = angle_in;
    assign idx     = 5'(cnt_q);
    assign atan_z  = {1'b0, atan_lut(idx)};
    assign x_sh    = x_q >>> cnt_q;
    assign y_sh    = y_q >>> cnt_q;

    // 34x32 signed product, gain-corrected value sits in bits [62:31]
    assign prod_x = $signed({{32{x_q[33]}}, x_q}) * $signed({34'd0, KINV});
    assign prod_y = $signed({{32{y_q[33]}}, y_q}) * $signed({34'd0, KINV});
    assign unused_prod_bits = ^{prod_x[65:63], prod_x[30:0], prod_y[65:63], prod_y[30:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        if (enable) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_ROT;
                        cnt_d   = '0;
                        // pre-rotate by +/-90 deg so the residual angle stays in CORDIC range
                        if (angle_s > ANG_P90) begin
                            x_d = '0;
                            y_d = mod_ext;
                            z_d = ang_ext - ANG_90_Z;
                        end else if (angle_s < ANG_M90) begin
                            x_d = '0;
                            y_d = -mod_ext;
                            z_d = ang_ext + ANG_90_Z;
                        end else begin
                            x_d = mod_ext;
                            y_d = '0;
                            z_d = ang_ext;
                        end
                    end else if (state_q == S_DONE) begin
                        state_d = S_IDLE;
                    end
                end
                S_ROT: begin
                    if (!z_q[32]) begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - atan_z;
                    end else begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + atan_z;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(NITER - 1)) begin
                        state_d = S_SCALE;
                        cnt_d   = '0;
                    end
                end
                S_SCALE: begin
                    xr_d    = prod_x[62:31];
                    yr_d    = prod_y[62:31];
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
        end
    end

    assign x_res = xr_q;
    assign y_res = yr_q;
    assign busy  = (state_q == S_ROT) || (state_q == S_SCALE);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_pol2rec23.sv
// Directed self-checking bench for pol2rec23: expected X/Y are hand-computed Q16.16 constants.
module tb_pol2rec23;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic [31:0] mod_in = '0;
    logic [31:0] angle_in = '0;
    logic [31:0] x_res, y_res;
    logic        busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;
    int lat;

    always #5 clk = ~clk;

    pol2rec23 #(.NITER(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .start    (start),
        .mod_in   (mod_in),
        .angle_in (angle_in),
        .x_res    (x_res),
        .y_res    (y_res),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk_val(input string tag, input longint got, input longint exp, input longint tol);
        longint diff;
        n_checks++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic launch(input logic [31:0] m, input logic [31:0] a);
        mod_in   = m;
        angle_in = a;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        busy_cnt = busy ? 1 : 0;
    endtask

    // counts edges after the start edge until done; optional enable gap and ignored restart
    task automatic wait_done(input int gap_at, input int gap_len, input int restart_at, output int n_lat);
        n_lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (done) begin
                n_lat = n;
                break;
            end
            if (n == gap_at) enable = 1'b0;
            if (n == gap_at + gap_len) enable = 1'b1;
            if (n == restart_at) begin
                start    = 1'b1;
                mod_in   = 32'h7FFF0000;
                angle_in = 32'h10000000;
            end
            if (n == restart_at + 1) start = 1'b0;
        end
        enable = 1'b1;
        start  = 1'b0;
    endtask

    task automatic conv(input string name, input logic [31:0] m, input logic [31:0] a,
                        input longint ex, input longint ey, input longint tol);
        launch(m, a);
        wait_done(-100, 0, -100, lat);
        chk_val({name, ".lat"}, lat, 33, 0);
        chk_val({name, ".x"}, $signed(x_res), ex, tol);
        chk_val({name, ".y"}, $signed(y_res), ey, tol);
    endtask

    initial begin
        #12;
        chk_val("rst.x", $signed(x_res), 0, 0);
        chk_val("rst.y", $signed(y_res), 0, 0);
        chk_val("rst.busy", busy, 0, 0);
        chk_val("rst.done", done, 0, 0);
        enable = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 10.0 at 0 deg, plus busy width and single-cycle done
        conv("m10_a0", 32'h000A0000, 32'h00000000, 655360, 0, 4);
        chk_val("m10_a0.busy_cyc", busy_cnt, 33, 0);
        chk_val("m10_a0.busy_at_done", busy, 0, 0);
        @(posedge clk); #1;
        chk_val("m10_a0.done_pulse", done, 0, 0);

        conv("m84_am45", 32'h0054DA52, 32'hD3000000, 3932160, -3932160, 4);
        conv("m84_ap45", 32'h0054DA52, 32'h2D000000, 3932160, 3932160, 4);
        conv("m42_a120", 32'h002A6D29, 32'h78000000, -1390228, 2407946, 4);
        conv("m42_am120", 32'h002A6D29, 32'h88000000, -1390228, -2407946, 4);
        conv("m42_a90", 32'h002A6D29, 32'h5A000000, 0, 2780457, 4);
        conv("mneg10_a0", 32'hFFF60000, 32'h00000000, -655360, 0, 4);

        // enable gap of 5 cycles and an ignored restart mid-conversion
        launch(32'h0054DA52, 32'hD3000000);
        wait_done(10, 5, 25, lat);
        chk_val("gap.lat", lat, 38, 0);
        chk_val("gap.busy_cyc", busy_cnt, 38, 0);
        chk_val("gap.x", $signed(x_res), 3932160, 4);
        chk_val("gap.y", $signed(y_res), -3932160, 4);

        // enable low while done is high stretches the pulse
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_val("stretch.done", done, 1, 0);
        chk_val("stretch.x", $signed(x_res), 3932160, 4);
        enable = 1'b1;
        @(posedge clk); #1;
        chk_val("stretch.done_end", done, 0, 0);

        // back-to-back: new start on the DONE-cycle edge
        launch(32'h000A0000, 32'h00000000);
        wait_done(-100, 0, -100, lat);
        chk_val("b2b_first.lat", lat, 33, 0);
        launch(32'h002A6D29, 32'h78000000);
        chk_val("b2b.busy", busy, 1, 0);
        chk_val("b2b.done", done, 0, 0);
        wait_done(-100, 0, -100, lat);
        chk_val("b2b.lat", lat, 33, 0);
        chk_val("b2b.x", $signed(x_res), -1390228, 4);
        chk_val("b2b.y", $signed(y_res), 2407946, 4);

        // asynchronous reset mid-conversion
        launch(32'h0054DA52, 32'h2D000000);
        repeat (16) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("arst.x", $signed(x_res), 0, 0);
        chk_val("arst.y", $signed(y_res), 0, 0);
        chk_val("arst.busy", busy, 0, 0);
        chk_val("arst.done", done, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        conv("m1_a30", 32'h00010000, 32'h1E000000, 56756, 32768, 4);

        conv("m0_a77", 32'h00000000, 32'h4D000000, 0, 0, 0);
        conv("m60_am45", 32'h003C0000, 32'hD3000000, 2780457, -2780457, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
